pipeline_ctrl: RTL

Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It drives the enable (stall) and clear (flush) inputs of the PC and every pipeline register, and generates EX-stage forwarding selects. It also runs the variable-latency data-memory handshake for the MEM stage, freezing the pipeline until the memory completes or times out. It keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall/flush sequencing, EX forwarding and MEM-stage memory handshake
// for the 5-stage RV32I pipeline, with saturating stall/flush performance counters.
module pipeline_ctrl #(
    parameter int          MEM_TIMEOUT = 255,
    parameter logic [1:0]  LOAD_SRC    = 2'b01,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             MemValidM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             timeout, mem_stall, lw_stall;

    function automatic logic [1:0] fwd(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                       input logic ww, input logic [4:0] rdw);
        return (wm && rdm != 5'd0 && rdm == rs) ? 2'b10 :
               (ww && rdw != 5'd0 && rdw == rs) ? 2'b01 : 2'b00;
    endfunction

    assign timeout   = state_q == S_WAIT && wait_cnt_q == 16'(MEM_TIMEOUT - 1);
    assign mem_stall = MemReqM && !MemReadyM && !timeout;
    assign lw_stall  = ResultSrcE == LOAD_SRC && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

    // Every output is gated by reset so an asynchronous reset silences the pipeline at once.
    always_comb begin
        MemValidM = !reset && MemReqM;
        StallF    = !reset && (mem_stall || lw_stall);
        StallD    = StallF;
        StallE    = !reset && mem_stall;
        StallM    = StallE;
        FlushW    = StallE;
        FlushE    = !reset && !mem_stall && (lw_stall || PCSrcE);
        FlushD    = !reset && !mem_stall && PCSrcE;
        ForwardAE = reset ? 2'b00 : fwd(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
        ForwardBE = reset ? 2'b00 : fwd(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end

    // Staying frozen is exactly the condition for being in WAIT next cycle.
    always_comb begin
        state_d     = mem_stall ? S_WAIT : S_RUN;
        wait_cnt_d  = state_q == S_RUN ? 16'd0 : wait_cnt_q + 16'd1;
        mem_err_d   = mem_err_q || (timeout && MemReqM && !MemReadyM);
        stall_cnt_d = (StallF && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (FlushD && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemErr      = mem_err_q;
    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;
endmodule
